// File: rtl/serial_frame_sequencer_pkg.sv
// Shared types for the serial frame sequencer: field codes, FSM encoding and the
// read-count width helper used by the top level and the buffer interface.
package serial_frame_sequencer_pkg;

  typedef logic [1:0] field_t;

  localparam field_t FIELD_CMD  = 2'd0;
  localparam field_t FIELD_ADDR = 2'd1;
  localparam field_t FIELD_DATA = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_GUARD  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5
  } seq_state_t;

  // Width needed to hold a bit count from 0 up to and including buf_size.
  function automatic int ctr_size(input int buf_size);
    return $clog2(buf_size + 1);
  endfunction

endpackage

// File: rtl/serial_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer (master) and one serial read buffer (slave).
interface serial_frame_sequencer_if #(
  parameter int BUF_SIZE = 32
) ();
  import serial_frame_sequencer_pkg::*;

  localparam int CTR_SIZE = ctr_size(BUF_SIZE);

  logic                buf_start;
  logic [CTR_SIZE-1:0] buf_read_count;
  logic                buf_abort;
  logic                buf_done;
  logic [BUF_SIZE-1:0] buf_data;

  modport master (
    output buf_start,
    output buf_read_count,
    output buf_abort,
    input  buf_done,
    input  buf_data
  );

  modport slave (
    input  buf_start,
    input  buf_read_count,
    input  buf_abort,
    output buf_done,
    output buf_data
  );

endinterface

// File: rtl/serial_field_align.sv
// Right-aligns an n-bit field captured by the read buffer; masks for MSB-first
// shifting, shifts down for LSB-first shifting. n >= BUF_SIZE passes data through.
module serial_field_align #(
  parameter int BUF_SIZE  = 32,
  parameter int CTR_SIZE  = 6,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic [BUF_SIZE-1:0] buf_data,
  input  logic [CTR_SIZE-1:0] n,
  output logic [BUF_SIZE-1:0] field_data
);

  generate
    if (LSB_FIRST) begin : g_lsb
      // LSB-first buffers fill from the top, so the field sits in the upper n bits.
      logic [CTR_SIZE-1:0] shift;
      assign shift      = CTR_SIZE'(BUF_SIZE) - n;
      assign field_data = (n >= CTR_SIZE'(BUF_SIZE)) ? buf_data : (buf_data >> shift);
    end else begin : g_msb
      logic [BUF_SIZE-1:0] mask;
      for (genvar gi = 0; gi < BUF_SIZE; gi++) begin : g_mask
        assign mask[gi] = (CTR_SIZE'(gi) < n);
      end
      assign field_data = buf_data & mask;
    end
  endgenerate

endmodule

// File: rtl/serial_frame_sequencer.sv
// Serial frame sequencer: walks a read buffer through CMD, optional ADDR and N DATA fields.
// Optional statistics counters are built when SEQ_STATS_EN is defined.
module serial_frame_sequencer
  import serial_frame_sequencer_pkg::*;
#(
  parameter int BUF_SIZE  = 32,
  parameter int CMD_BITS  = 8,
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         frame_active,
  serial_frame_sequencer_if.master     buf_if,
  output logic [BUF_SIZE-1:0]          field_data,
  output logic [1:0]                   field_type,
  output logic                         field_valid,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic                         busy
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0]                  frame_ok_cnt,
  output logic [15:0]                  frame_err_cnt
`endif
);

  localparam int CTR_SIZE = ctr_size(BUF_SIZE);

  localparam logic [CTR_SIZE-1:0] CMD_N  = CTR_SIZE'(CMD_BITS);
  localparam logic [CTR_SIZE-1:0] ADDR_N = CTR_SIZE'(ADDR_BITS);
  localparam logic [CTR_SIZE-1:0] DATA_N = CTR_SIZE'(DATA_BITS);

  seq_state_t          state_reg, state_next;
  field_t              cur_field_reg, cur_field_next;
  logic [3:0]          word_ctr_reg, word_ctr_next;
  logic                has_addr_reg, has_addr_next;
  logic                active_d_reg;
  logic [CTR_SIZE-1:0] read_count_reg, read_count_next;
  logic                start_reg, start_next;
  logic                abort_reg, abort_next;
  logic [BUF_SIZE-1:0] field_data_reg, field_data_next;
  field_t              field_type_reg, field_type_next;
  logic                valid_reg, valid_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic [BUF_SIZE-1:0] aligned;
  field_t              target;
  logic                finish;

  function automatic logic [CTR_SIZE-1:0] field_len(input field_t f);
    case (f)
      FIELD_CMD:  return CMD_N;
      FIELD_ADDR: return ADDR_N;
      default:    return DATA_N;
    endcase
  endfunction

  // read_count_reg still holds the width of the field being captured while in WAIT.
  serial_field_align #(
    .BUF_SIZE  (BUF_SIZE),
    .CTR_SIZE  (CTR_SIZE),
    .LSB_FIRST (LSB_FIRST)
  ) u_align (
    .buf_data   (buf_if.buf_data),
    .n          (read_count_reg),
    .field_data (aligned)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cur_field_reg  <= FIELD_CMD;
      word_ctr_reg   <= 4'd0;
      has_addr_reg   <= 1'b0;
      active_d_reg   <= 1'b0;
      read_count_reg <= '0;
      start_reg      <= 1'b0;
      abort_reg      <= 1'b0;
      field_data_reg <= '0;
      field_type_reg <= FIELD_CMD;
      valid_reg      <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_field_reg  <= cur_field_next;
      word_ctr_reg   <= word_ctr_next;
      has_addr_reg   <= has_addr_next;
      active_d_reg   <= frame_active;
      read_count_reg <= read_count_next;
      start_reg      <= start_next;
      abort_reg      <= abort_next;
      field_data_reg <= field_data_next;
      field_type_reg <= field_type_next;
      valid_reg      <= valid_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cur_field_next  = cur_field_reg;
    word_ctr_next   = word_ctr_reg;
    has_addr_next   = has_addr_reg;
    read_count_next = read_count_reg;
    field_data_next = field_data_reg;
    field_type_next = field_type_reg;
    start_next      = 1'b0;
    abort_next      = 1'b0;
    valid_next      = 1'b0;
    done_next       = 1'b0;
    err_next        = 1'b0;
    target          = FIELD_DATA;
    finish          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (frame_active && !active_d_reg) begin
          state_next      = ST_ARM;
          cur_field_next  = FIELD_CMD;
          start_next      = 1'b1;
          read_count_next = field_len(FIELD_CMD);
        end
      end

      ST_ARM, ST_GUARD: begin
        if (!frame_active) begin
          state_next = ST_IDLE;
          abort_next = 1'b1;
          err_next   = 1'b1;
        end else begin
          state_next = (state_reg == ST_ARM) ? ST_GUARD : ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A completed field wins over a simultaneous frame drop; NEXT decides what follows.
        if (buf_if.buf_done) begin
          field_data_next = aligned;
          field_type_next = cur_field_reg;
          valid_next      = 1'b1;
          state_next      = ST_NEXT;
          if (cur_field_reg == FIELD_CMD) begin
            has_addr_next = aligned[CMD_BITS-1];
            word_ctr_next = aligned[3:0];
          end
        end else if (!frame_active) begin
          state_next = ST_IDLE;
          abort_next = 1'b1;
          err_next   = 1'b1;
        end
      end

      ST_NEXT: begin
        case (cur_field_reg)
          FIELD_CMD: begin
            if (has_addr_reg) target = FIELD_ADDR;
            else              finish = (word_ctr_reg == 4'd0);
          end
          FIELD_ADDR: finish = (word_ctr_reg == 4'd0);
          default: begin
            word_ctr_next = word_ctr_reg - 4'd1;
            finish        = (word_ctr_reg == 4'd1);
          end
        endcase

        // The final field is complete, so a frame drop here is a normal end.
        if (finish) begin
          state_next = ST_FINISH;
          done_next  = 1'b1;
        end else if (!frame_active) begin
          state_next = ST_IDLE;
          abort_next = 1'b1;
          err_next   = 1'b1;
        end else begin
          state_next      = ST_ARM;
          cur_field_next  = target;
          start_next      = 1'b1;
          read_count_next = field_len(target);
        end
      end

      ST_FINISH: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  assign buf_if.buf_start      = start_reg;
  assign buf_if.buf_read_count = read_count_reg;
  assign buf_if.buf_abort      = abort_reg;

  assign field_data  = field_data_reg;
  assign field_type  = field_type_reg;
  assign field_valid = valid_reg;
  assign frame_done  = done_reg;
  assign frame_err   = err_reg;
  assign busy        = (state_reg != ST_IDLE);

`ifdef SEQ_STATS_EN
  logic [15:0] ok_cnt_reg;
  logic [15:0] err_cnt_reg;

  // Counters saturate so a long-running link never wraps back to a small count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_reg  <= 16'd0;
      err_cnt_reg <= 16'd0;
    end else begin
      if (done_next && (ok_cnt_reg != 16'hFFFF))  ok_cnt_reg  <= ok_cnt_reg + 16'd1;
      if (err_next && (err_cnt_reg != 16'hFFFF)) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign frame_ok_cnt  = ok_cnt_reg;
  assign frame_err_cnt = err_cnt_reg;
`endif

endmodule
